// File: rtl/keypad_pkg.sv
// Shared constants, state/result encodings and the frame classifier for the
// matrix keypad front end.
package keypad_pkg;

  localparam int NROWS = 4;
  localparam int NCOLS = 4;

  // Indexed by row*NCOLS + col.
  localparam logic [3:0] KEY_MAP [NROWS*NCOLS] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  typedef enum logic [1:0] {ST_IDLE, ST_CAND, ST_HELD} state_t;
  typedef enum logic [1:0] {FR_NONE, FR_KEY, FR_GHOST} frame_res_t;

  typedef struct packed {
    frame_res_t res;
    logic [3:0] code;
  } frame_t;

  // code is only meaningful when exactly one intersection is active.
  function automatic frame_t classify(input logic [NROWS*NCOLS-1:0] hits);
    frame_t f;
    int n;
    n = 0;
    f.code = 4'h0;
    for (int i = 0; i < NROWS*NCOLS; i++) begin
      if (hits[i]) begin
        n++;
        f.code = KEY_MAP[i];
      end
    end
    f.res = (n == 0) ? FR_NONE : ((n == 1) ? FR_KEY : FR_GHOST);
    return f;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Synchronous key queue with first-word fall-through head register and a
// sticky overflow flag for pushes dropped while full.
module key_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full,
  output logic         overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [AW:0]   count_reg, count_next;
  logic [W-1:0]  dout_reg;
  logic          empty_reg, full_reg, overflow_reg;
  logic          pop_ok, push_ok;

  // A pop frees a slot in the same cycle, so a push alongside it is accepted.
  assign pop_ok  = pop && !empty_reg;
  assign push_ok = push && (!full_reg || pop_ok);

  always_comb begin
    count_next = count_reg;
    if (push_ok && !pop_ok)
      count_next = count_reg + (AW+1)'(1);
    else if (!push_ok && pop_ok)
      count_next = count_reg - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      dout_reg     <= '0;
      empty_reg    <= 1'b1;
      full_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      empty_reg <= (count_next == '0);
      full_reg  <= (count_next == (AW+1)'(DEPTH));
      if (push_ok)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok) begin
        rd_ptr_reg   <= rd_ptr_reg + AW'(1);
        overflow_reg <= 1'b0;
        if (count_reg > (AW+1)'(1))
          dout_reg <= mem[rd_ptr_reg + AW'(1)];
        else if (push_ok)
          dout_reg <= din;
      end else begin
        if (push_ok && empty_reg)
          dout_reg <= din;
        if (push && full_reg)
          overflow_reg <= 1'b1;
      end
    end
  end

  assign dout     = dout_reg;
  assign empty    = empty_reg;
  assign full     = full_reg;
  assign overflow = overflow_reg;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row synchroniser, column scan, frame collection,
// frame-level debounce and a key FIFO for the CPU read path.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV   = 4,
  parameter int DEBOUNCE   = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  input  logic       key_rd,
  output logic [3:0] key_code,
  output logic       key_empty,
  output logic       key_full,
  output logic       key_overflow
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE + 1);

  logic [3:0]             rows_s1_reg, rows_s2_reg;
  logic [DIV_W-1:0]       div_cnt_reg;
  logic [1:0]             col_idx_reg, col_next;
  logic [3:0]             cols_reg;
  logic [NROWS*NCOLS-1:0] hits_reg, frame_hits;
  logic [NROWS-1:0]       col_hits;
  logic                   dwell_end, frame_end;
  frame_t                 fr;

  state_t                 state_reg;
  logic [3:0]             key_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic                   push_reg;

  for (genvar gi = 0; gi < NROWS; gi++) begin : g_row_hit
    assign col_hits[gi] = ~rows_s2_reg[gi];
  end

  assign col_next  = col_idx_reg + 2'd1;
  assign dwell_end = (div_cnt_reg == DIV_W'(SCAN_DIV - 1));
  assign frame_end = dwell_end && (col_idx_reg == 2'd3);

  // Splice the column being sampled now into the frame, so the last
  // column is visible to the frame-end evaluation in the same cycle.
  always_comb begin
    frame_hits = hits_reg;
    for (int r = 0; r < NROWS; r++)
      frame_hits[r*NCOLS + int'(col_idx_reg)] = col_hits[r];
  end

  assign fr = classify(frame_hits);

  always_ff @(posedge clk) begin
    if (rst) begin
      rows_s1_reg <= 4'hF;
      rows_s2_reg <= 4'hF;
      div_cnt_reg <= '0;
      col_idx_reg <= '0;
      cols_reg    <= 4'b1110;
      hits_reg    <= '0;
    end else begin
      rows_s1_reg <= rows;
      rows_s2_reg <= rows_s1_reg;
      if (dwell_end) begin
        div_cnt_reg <= '0;
        col_idx_reg <= col_next;
        cols_reg    <= ~(4'b0001 << col_next);
        hits_reg    <= frame_hits;
      end else begin
        div_cnt_reg <= div_cnt_reg + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      key_reg   <= '0;
      cnt_reg   <= '0;
      push_reg  <= 1'b0;
    end else begin
      push_reg <= 1'b0;
      if (frame_end) begin
        case (state_reg)
          ST_IDLE, ST_CAND: begin
            if (fr.res != FR_KEY) begin
              state_reg <= ST_IDLE;
              cnt_reg   <= '0;
            end else if (state_reg == ST_CAND && fr.code == key_reg &&
                         cnt_reg != CNT_W'(DEBOUNCE - 1)) begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end else if (state_reg == ST_CAND && fr.code == key_reg) begin
              push_reg  <= 1'b1;
              state_reg <= ST_HELD;
              cnt_reg   <= '0;
            end else if (DEBOUNCE == 1) begin
              key_reg   <= fr.code;
              push_reg  <= 1'b1;
              state_reg <= ST_HELD;
              cnt_reg   <= '0;
            end else begin
              key_reg   <= fr.code;
              state_reg <= ST_CAND;
              cnt_reg   <= CNT_W'(1);
            end
          end
          ST_HELD: begin
            if (fr.res == FR_KEY && fr.code == key_reg) begin
              cnt_reg <= '0;
            end else if (cnt_reg == CNT_W'(DEBOUNCE - 1)) begin
              state_reg <= ST_IDLE;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
          default: begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
          end
        endcase
      end
    end
  end

  key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (4)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_reg),
    .din      (key_reg),
    .pop      (key_rd),
    .dout     (key_code),
    .empty    (key_empty),
    .full     (key_full),
    .overflow (key_overflow)
  );

  assign cols = cols_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a simulated key matrix, a frame-level reference
// model with a queue, per-cycle comparison plus hand-computed checkpoints.
module tb_keypad_scanner;

  localparam int FRAME = 16;

  logic       clk = 1'b0;
  logic       rst, key_rd;
  logic [3:0] rows, cols, key_code;
  logic       key_empty, key_full, key_overflow;
  logic [15:0] press;

  int n_tests = 0;
  int n_fail  = 0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .rows         (rows),
    .cols         (cols),
    .key_rd       (key_rd),
    .key_code     (key_code),
    .key_empty    (key_empty),
    .key_full     (key_full),
    .key_overflow (key_overflow)
  );

  always #5 clk = ~clk;

  // Passive matrix: a pressed switch pulls its row low while its column is driven.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (press[r*4 + c] && !cols[c]) rows[r] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model, tracked per frame.
  logic [3:0] code_of [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
  logic [3:0] q[$];
  int         t, phase, mkey, streak, seen, pushes;
  bit         ovf_m, pend, started, in_rst;
  logic [3:0] pend_code, ec;

  always @(posedge clk) begin
    if (rst) begin
      started = 1'b1; in_rst = 1'b1;
      t = 0; q.delete(); ovf_m = 1'b0; pend = 1'b0;
      phase = 0; mkey = -1; streak = 0;
    end else if (started) begin
      in_rst = 1'b0;
      t++;
      if (key_rd && q.size() > 0) begin
        void'(q.pop_front());
        ovf_m = 1'b0;
      end
      if (pend) begin
        pushes++;
        if (q.size() < 4) q.push_back(pend_code);
        else ovf_m = 1'b1;
        pend = 1'b0;
      end
      if (t % FRAME == 0) begin
        seen = -1;
        if ($countones(press) == 1)
          for (int i = 0; i < 16; i++) if (press[i]) seen = i;
        if (phase == 0 || phase == 1) begin
          if (seen < 0) begin phase = 0; streak = 0; end
          else if (phase == 1 && seen == mkey) streak++;
          else begin phase = 1; mkey = seen; streak = 1; end
          if (phase == 1 && streak == 3) begin
            pend = 1'b1; pend_code = code_of[mkey]; phase = 2; streak = 0;
          end
        end else begin
          if (seen == mkey) streak = 0;
          else streak++;
          if (streak == 3) begin phase = 0; streak = 0; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      ec = 4'hF;
      ec[(t / 4) % 4] = 1'b0;
      chk("cols", 32'(cols), 32'(ec));
      chk("key_empty", 32'(key_empty), 32'(q.size() == 0));
      chk("key_full", 32'(key_full), 32'(q.size() == 4));
      chk("key_overflow", 32'(key_overflow), 32'(ovf_m));
      if (q.size() > 0) chk("key_code", 32'(key_code), 32'(q[0]));
      if (in_rst) chk("key_code_rst", 32'(key_code), 32'h0);
    end
  end

  task automatic run_frames(input int n);
    repeat (FRAME * n) @(negedge clk);
  endtask

  task automatic pop_frame();
    key_rd = 1'b1;
    @(negedge clk);
    key_rd = 1'b0;
    repeat (FRAME - 1) @(negedge clk);
  endtask

  task automatic tap_key(input int idx);
    press = 16'(1) << idx;
    run_frames(3);
    press = '0;
    run_frames(3);
  endtask

  initial begin
    pushes = 0;
    press = '0; key_rd = 1'b0; rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cols", 32'(cols), 32'hE);
    chk("rst_empty", 32'(key_empty), 32'h1);
    chk("rst_code", 32'(key_code), 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("scan_col1", 32'(cols), 32'hD);
    repeat (12) @(negedge clk);
    chk("scan_wrap", 32'(cols), 32'hE);

    // Hold r1c2 for 6 frames: single push of code 6.
    press = 16'(1) << 6;
    run_frames(6);
    chk("hold_code", 32'(key_code), 32'h6);
    chk("hold_empty", 32'(key_empty), 32'h0);
    press = '0;
    run_frames(3);
    chk("hold_model_pushes", 32'(pushes), 32'd1);
    pop_frame();
    chk("hold_popped", 32'(key_empty), 32'h1);

    // Bouncing r0c0 never reaches the debounce count.
    for (int i = 0; i < 4; i++) begin
      press = 16'h0001; run_frames(2);
      press = '0;       run_frames(1);
    end
    chk("bounce_empty", 32'(key_empty), 32'h1);

    // Ghost: two keys together, then one of them alone.
    press = 16'h0003; run_frames(5);
    chk("ghost_empty", 32'(key_empty), 32'h1);
    press = 16'h0001; run_frames(4);
    chk("deghost_code", 32'(key_code), 32'h1);
    press = '0; run_frames(3);
    pop_frame();

    // Overflow: five keys with no reads.
    tap_key(0); tap_key(1); tap_key(2); tap_key(3); tap_key(5);
    chk("ovf_full", 32'(key_full), 32'h1);
    chk("ovf_flag", 32'(key_overflow), 32'h1);
    chk("ovf_head", 32'(key_code), 32'h1);
    pop_frame();
    chk("ovf_clear", 32'(key_overflow), 32'h0);
    chk("ovf_pop1", 32'(key_code), 32'h2);
    pop_frame();
    chk("ovf_pop2", 32'(key_code), 32'h3);
    pop_frame();
    chk("ovf_pop3", 32'(key_code), 32'hA);
    pop_frame();
    chk("ovf_drained", 32'(key_empty), 32'h1);

    // Push coinciding with a pop while full.
    tap_key(0); tap_key(1); tap_key(2); tap_key(3);
    chk("coin_full_before", 32'(key_full), 32'h1);
    press = 16'(1) << 5;
    run_frames(3);
    pop_frame();
    chk("coin_head", 32'(key_code), 32'h2);
    chk("coin_full", 32'(key_full), 32'h1);
    chk("coin_noovf", 32'(key_overflow), 32'h0);
    chk("coin_model_size", 32'(q.size()), 32'd4);
    press = '0; run_frames(2);
    pop_frame(); chk("coin_pop1", 32'(key_code), 32'h3);
    pop_frame(); chk("coin_pop2", 32'(key_code), 32'hA);
    pop_frame(); chk("coin_pop3", 32'(key_code), 32'h5);
    pop_frame(); chk("coin_drained", 32'(key_empty), 32'h1);

    // Reset while a candidate is partially debounced.
    press = 16'(1) << 6;
    run_frames(2);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_cols", 32'(cols), 32'hE);
    chk("mid_rst_empty", 32'(key_empty), 32'h1);
    chk("mid_rst_full", 32'(key_full), 32'h0);
    chk("mid_rst_ovf", 32'(key_overflow), 32'h0);
    chk("mid_rst_code", 32'(key_code), 32'h0);
    @(negedge clk);
    press = '0;
    rst = 1'b0;
    run_frames(4);
    chk("mid_rst_nopush", 32'(key_empty), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Matrix-keypad front end for the peripheral controller. It drives the 4 keypad columns one at a time and samples the 4 rows, then debounces and de-ghosts the result. Each accepted key press is queued as a 4-bit hex code in a small FIFO, and the peripheral controller's CPU-facing read path pops the FIFO. It runs on the divided clock (`clkd`) and replaces direct row/column handling inside `peripheral_controller`.

## Interface
Parameters:
- `SCAN_DIV`, 4: clk cycles each column is driven; must be ≥3.
- `DEBOUNCE`, 3: consecutive identical frames required to accept a press or a release; must be ≥1.
- `FIFO_DEPTH`, 4: key queue entries; must be a power of 2.

Ports:
- `clk`, in, 1: divided system clock; all logic on posedge.
- `rst`, in, 1: synchronous, active-high reset.
- `rows`, in, 4: keypad rows, active-low with pull-ups; asynchronous to `clk`.
- `cols`, out, 4: column drive, active-low, one-hot-zero.
- `key_rd`, in, 1: pop request; single-cycle pulse.
- `key_code`, out, 4: FIFO head, first-word fall-through.
- `key_empty`, out, 1: FIFO empty.
- `key_full`, out, 1: FIFO full.
- `key_overflow`, out, 1: sticky flag; a press was dropped because the FIFO was full.

## Operation
- **Reset values**:
  - `cols`=4'b1110, `key_code`=0, `key_empty`=1, `key_full`=0, `key_overflow`=0.
  - FSM in IDLE; all counters 0; row synchroniser flops = 4'hF.
- **Synchroniser**: `rows` passes through 2 flops.
- **Column scan**: `col_idx` steps 0→1→2→3→0 every `SCAN_DIV` cycles; `cols` = ~(1<<`col_idx`).
- **Row sampling**: the synchronised rows are sampled on the last dwell cycle of each column.
- **Frame**: 4 columns. At frame end the frame result is one of:
  - exactly one row/column intersection low → KEY(code);
  - none low → NONE;
  - two or more low → GHOST, treated as NONE.
- **Key map** (row r, col c → code):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- **Debounce FSM**, evaluated only at frame end:
  - IDLE: KEY(k) → CAND, latch k, cnt=1.
  - CAND: same k → cnt+1. When cnt reaches `DEBOUNCE` → push k, go to HELD, cnt=0. A different key → restart CAND with the new key, cnt=1. NONE → IDLE.
  - HELD: the latched key stays down → cnt=0. Anything else (NONE, GHOST or a different key) → cnt+1. When cnt reaches `DEBOUNCE` → IDLE. No auto-repeat; a different key requires a release first.
- **FIFO**:
  - A push while full is dropped and sets `key_overflow`.
  - `key_rd` while empty is ignored.
  - Push and pop in the same cycle while full: both take effect, count unchanged, no overflow.
  - Push and pop in the same cycle while empty: push only.
  - `key_overflow` clears on any accepted pop.
- **Mid-operation reset**: `rst` in any state immediately returns all outputs to their reset values; any partially debounced key is discarded.

## Timing
- Frame length = 4·`SCAN_DIV` cycles.
- The sample taken at the end of each column's dwell reflects rows from 2 cycles earlier. This is why `SCAN_DIV` ≥3 is required: the sampled value must belong to the current column.
- Push happens 1 cycle after the frame-end evaluation of the `DEBOUNCE`-th matching frame. `key_empty` falls and `key_code` becomes valid on that same push edge, i.e. registered, visible the cycle after the evaluation.
- Pop: `key_code`/`key_empty`/`key_full` update on the edge that samples `key_rd`=1.
- All outputs are registered; there is no combinational path from `rows` or `key_rd` to any output.

## Structure
- Package `keypad_pkg`:
  - `NROWS`/`NCOLS` = 4;
  - key-map constant array (16×4 bits);
  - FSM state encoding IDLE/CAND/HELD;
  - frame-result encoding NONE/KEY/GHOST.
- Sub-module `key_fifo`: parameterised sync FIFO with `FIFO_DEPTH`, 4-bit data, push, pop, empty, full, overflow, and first-word fall-through output.
- Top level holds the synchroniser, scan counter, frame collector and debounce FSM.

## Test plan
All scenarios use `SCAN_DIV`=4, `DEBOUNCE`=3 (frame = 16 cycles).
- Reset → `cols`=1110, `key_empty`=1, `key_code`=0. After 4 cycles `cols`=1101; after 16 cycles `cols`=1110 again.
- Hold r1c2 for 6 frames, then release → exactly one push: `key_code`=6, `key_empty`=0 after the 3rd frame. `key_rd` → `key_empty`=1. No second push.
- Bounce r0c0 pressed 2 frames / released 1 frame, ×4 → FIFO stays empty.
- Press r0c0 and r0c1 together for 5 frames → GHOST, no push. Release r0c1 and keep r0c0 for 3 frames → push code 1.
- Press/release keys 1, 2, 3, A, 5 in sequence with no reads → `key_full`=1, `key_overflow`=1. Four pops yield 1, 2, 3, A; `key_overflow` clears on the first pop.
- With the FIFO full, a push coincides with `key_rd` → head advances, count stays 4, `key_overflow` stays 0. Separately, assert `rst` in CAND after 2 matching frames → no push and all outputs at reset values.
